// File: rtl/posit_mul_scheduler.sv
// Round-robin scheduler that shares one external posit multiplier between two
// requesters, waits out the fixed multiplier latency and returns the product.
module posit_mul_scheduler #(
  parameter int N           = 16,
  parameter int RES_W       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [RES_W-1:0] rsp0_result,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [RES_W-1:0] rsp1_result,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  input  logic [RES_W-1:0] mul_result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT = 4'(MUL_LATENCY);

  state_t           state, state_next;
  logic [3:0]       count;
  logic             owner;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic             rsp_done;
  logic [RES_W-1:0] result_q;

  // Round-robin: on a tie the requester that was not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Ready is masked by reset so nothing looks accepted while the block is held.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = ~rst & req0_valid & ~grant;
        req1_ready = ~rst & req1_valid & grant;
        if (req0_ready || req1_ready) state_next = WAIT;
      end
      WAIT: begin
        if (count == 4'd1) state_next = RESP;
      end
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        rsp_done   = owner ? rsp1_ready : rsp0_ready;
        if (rsp_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = req0_ready | req1_ready;

  // Operands stay latched through WAIT so the multiplier sees them stable for
  // exactly MUL_LATENCY cycles; the product is sampled on the last of those.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a      <= '0;
      mul_b      <= '0;
      owner      <= 1'b0;
      count      <= 4'd0;
      result_q   <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mul_a <= grant ? req1_a : req0_a;
            mul_b <= grant ? req1_b : req0_b;
            owner <= grant;
            count <= LAT;
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) result_q <= mul_result;
        end
        RESP: begin
          if (rsp_done) last_grant <= owner;
        end
        default: ;
      endcase
    end
  end

  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign busy        = (state != IDLE);

endmodule
